// File: rtl/fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_buffer
// Purpose  : Fetch PC owner and req/ack prefetch FIFO feeding the IF/ID register.
//            Optional same-cycle bypass selected by macro FETCH_BUF_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     R,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     id_le,
    output logic                     im_req,
    output logic [31:0]              im_addr,
    input  logic                     im_ack,
    input  logic [31:0]              im_data,
    output logic                     if_valid,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [1:0]    S_IDLE  = 2'd0;
    localparam logic [1:0]    S_REQ   = 2'd1;
    localparam logic [1:0]    S_DROP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   tgt_q, tgt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d, count_next;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [31:0] w_rpc;
    logic        w_unused_rpc;
    logic        w_empty, w_byp, w_push, w_pop, w_fifo_pop;

    assign w_rpc        = {redirect_pc[31:2], 2'b00};
    assign w_unused_rpc = ^redirect_pc[1:0];
    assign w_empty      = (count_q == '0);

`ifdef FETCH_BUF_BYPASS_EN
    assign w_byp = w_empty & (state_q == S_REQ) & im_ack & ~redirect;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed word that is consumed on the spot never enters the FIFO.
    assign w_pop      = if_valid & id_le & ~redirect;
    assign w_fifo_pop = w_pop & ~w_empty;
    assign w_push     = (state_q == S_REQ) & im_ack & ~redirect & ~(w_byp & id_le);
    assign count_next = count_q + CW'(w_push) - CW'(w_fifo_pop);

    // State register
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q  <= S_IDLE;
            fpc_q    <= RESET_PC;
            tgt_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            tgt_q    <= tgt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= fpc_q;
            instr_mem_q[wr_ptr_q] <= im_data;
        end
    end

    // Next-state: fpc keeps the outstanding address while DROP waits for its ack.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        tgt_d   = tgt_q;
        if (redirect) begin
            case (state_q)
                S_DROP: begin
                    tgt_d = w_rpc;
                    if (im_ack) begin
                        state_d = S_REQ;
                        fpc_d   = w_rpc;
                    end
                end
                S_REQ: begin
                    if (im_ack) begin
                        fpc_d = w_rpc;
                    end else begin
                        state_d = S_DROP;
                        tgt_d   = w_rpc;
                    end
                end
                default: begin
                    state_d = S_REQ;
                    fpc_d   = w_rpc;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_next < C_DEPTH) state_d = S_REQ;
                end
                S_REQ: begin
                    if (im_ack) begin
                        fpc_d = fpc_q + 32'd4;
                        if (!(count_next < C_DEPTH)) state_d = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (im_ack) begin
                        state_d = S_REQ;
                        fpc_d   = tgt_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_next;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_fifo_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            if (w_push)     wr_ptr_d = wr_ptr_q + PW'(1);
        end
    end

    // Outputs
    always_comb begin
        im_req    = (state_q == S_REQ) | (state_q == S_DROP);
        im_addr   = fpc_q;
        occupancy = count_q;
        if_valid  = ~w_empty | w_byp;
        if_pc     = 32'h0;
        if_instr  = 32'h0;
        if (!w_empty) begin
            if_pc    = pc_mem_q[rd_ptr_q];
            if_instr = instr_mem_q[rd_ptr_q];
        end else if (w_byp) begin
            if_pc    = fpc_q;
            if_instr = im_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_buffer
// Purpose  : Directed self-checking bench for fetch_prefetch_buffer (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        R = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_le = 1'b0;
    logic        im_req, im_ack, if_valid;
    logic [31:0] im_addr, im_data, if_pc, if_instr;
    logic [$clog2(DEPTH):0] occupancy;

    int n_assert = 0;
    int n_fail   = 0;
    int mem_lat  = 0;
    bit mem_on   = 1'b0;
    int wcnt;

    fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .R(R), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_le(id_le), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
        .im_data(im_data), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory: acks once a request has been held for mem_lat cycles.
    always_ff @(posedge clk or negedge R) begin
        if (!R)                   wcnt <= 0;
        else if (!im_req || im_ack) wcnt <= 0;
        else                      wcnt <= wcnt + 1;
    end

    always_comb begin
        im_ack  = mem_on && im_req && (wcnt >= mem_lat);
        im_data = im_ack ? mw(im_addr) : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(im_req),    32'h0);
        chk({tag, "_addr"},  im_addr,        32'h0);
        chk({tag, "_valid"}, 32'(if_valid),  32'h0);
        chk({tag, "_pc"},    if_pc,          32'h0);
        chk({tag, "_instr"}, if_instr,       32'h0);
        chk({tag, "_occ"},   32'(occupancy), 32'h0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk_reset("rst");

        // Zero-wait streaming, consumer always ready
        R = 1'b1; id_le = 1'b1; mem_on = 1'b1;
        @(negedge clk);
        chk("t1_first_req", 32'(im_req), 32'h1);
        chk("t1_first_addr", im_addr, 32'h0);
        chk("t1_not_valid", 32'(if_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_pc", if_pc, 32'(4 * k));
            chk("t1_instr", if_instr, mw(32'(4 * k)));
            chk("t1_occ", 32'(occupancy), 32'h1);
        end

        // Saturation with consumer stalled
        R = 1'b0; id_le = 1'b0; #1;
        @(negedge clk); R = 1'b1;
        repeat (6) @(negedge clk);
        chk("t2_occ_full", 32'(occupancy), 32'h4);
        chk("t2_req_low", 32'(im_req), 32'h0);
        chk("t2_head0", if_pc, 32'h0);
        chk("t2_instr0", if_instr, mw(32'h0));
        id_le = 1'b1;
        @(negedge clk);
        chk("t2_head4", if_pc, 32'h4);
        chk("t2_resume_req", 32'(im_req), 32'h1);
        chk("t2_resume_addr", im_addr, 32'h10);
        @(negedge clk); chk("t2_head8", if_pc, 32'h8);
        @(negedge clk); chk("t2_head12", if_pc, 32'hC);
        @(negedge clk); chk("t2_head16", if_pc, 32'h10);

        // Redirect with three entries queued, zero-wait memory
        R = 1'b0; id_le = 1'b0; #1;
        @(negedge clk); R = 1'b1;
        repeat (4) @(negedge clk);
        chk("t3_occ3", 32'(occupancy), 32'h3);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        chk("t3_occ_flush", 32'(occupancy), 32'h0);
        chk("t3_addr", im_addr, 32'h100);
        chk("t3_req", 32'(im_req), 32'h1);
        chk("t3_nvalid", 32'(if_valid), 32'h0);
        @(negedge clk);
        chk("t3_valid", 32'(if_valid), 32'h1);
        chk("t3_pc", if_pc, 32'h100);
        chk("t3_instr", if_instr, mw(32'h100));

        // Unaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h303;
        @(negedge clk);
        redirect = 1'b0;
        chk("t5_addr_align", im_addr, 32'h300);
        chk("t5_occ", 32'(occupancy), 32'h0);
        @(negedge clk);
        chk("t5_pc", if_pc, 32'h300);

        // Redirect while a slow request is outstanding
        R = 1'b0; mem_lat = 3; id_le = 1'b1; #1;
        @(negedge clk); R = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (im_req === 1'b1 && im_addr === 32'h8) break;
        end
        chk("t4_reach8", im_addr, 32'h8);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        chk("t4_hold8_a", im_addr, 32'h8);
        chk("t4_hold_req", 32'(im_req), 32'h1);
        chk("t4_flushed", 32'(if_valid), 32'h0);
        @(negedge clk);
        chk("t4_hold8_b", im_addr, 32'h8);
        @(negedge clk);
        chk("t4_new_addr", im_addr, 32'h200);
        for (int i = 0; i < 4; i++) begin
            chk("t4_discard", 32'(if_valid), 32'h0);
            @(negedge clk);
        end
        chk("t4_valid", 32'(if_valid), 32'h1);
        chk("t4_pc", if_pc, 32'h200);

        // Two back-to-back redirects while a request is outstanding
        redirect = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_pc = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        chk("t6_drop_addr", im_addr, 32'h204);
        chk("t6_occ", 32'(occupancy), 32'h0);
        repeat (2) @(negedge clk);
        chk("t6_target", im_addr, 32'h80);
        for (int i = 0; i < 4; i++) begin
            chk("t6_discard", 32'(if_valid), 32'h0);
            @(negedge clk);
        end
        chk("t6_valid", 32'(if_valid), 32'h1);
        chk("t6_pc", if_pc, 32'h80);

        // Asynchronous reset during an outstanding request
        @(negedge clk);
        R = 1'b0; #1;
        chk_reset("t7");
        mem_lat = 0;
        @(negedge clk); R = 1'b1;
        @(negedge clk);
        chk("t7_req", 32'(im_req), 32'h1);
        chk("t7_addr", im_addr, 32'h0);
        @(negedge clk);
        chk("t7_pc", if_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_buffer.md
# fetch_prefetch_buffer

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to a multi-cycle instruction memory over a req/ack handshake. Fetched instructions are queued with their PCs in a small FIFO, and the head entry is presented to IF/ID. The IF load enable pops the FIFO; a redirect from the branch/call/jmpl path flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock.
- R  in  1  asynchronous, active-low reset.
- redirect  in  1  taken branch/call/jmpl; flush and refetch.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and forced to 0.
- id_le  in  1  IF/ID load enable; 1 = consumer accepts the head this cycle.
- im_req  out  1  instruction-memory request.
- im_addr  out  32  word address of the request.
- im_ack  in  1  memory returns im_data this cycle.
- im_data  in  32  instruction word; valid only when im_ack=1.
- if_valid  out  1  head entry valid.
- if_pc  out  32  PC of the head entry; 0 when empty.
- if_instr  out  32  instruction of the head entry; 0 when empty.
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

## Operation
- Registers:
  - fpc: fetch PC.
  - state: IDLE, REQ, or DROP.
  - FIFO: DEPTH × {pc, instr}, with rd_ptr, wr_ptr, count.
- pop = if_valid & id_le & ~redirect.
- push = (state==REQ) & im_ack & ~redirect.
- count_next = count + push − pop.
- im_req = (state==REQ) | (state==DROP); it is a registered state decode.
- im_addr = fpc in REQ; in DROP it holds the address of the outstanding request.
- Once im_req rises, im_addr is held stable until the cycle in which im_ack=1.
- IDLE:
  - If count_next < DEPTH, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - On im_ack with no redirect: push {fpc, im_data} and set fpc += 4 (mod 2^32).
  - After that ack, stay in REQ if count_next < DEPTH; otherwise go to IDLE.
  - With no ack, hold.
- DROP:
  - Wait for im_ack and discard the data.
  - Then go to REQ with fpc = the latched redirect target.
- Redirect (highest priority, in any state):
  - count, rd_ptr and wr_ptr clear.
  - No push and no pop occur that cycle.
  - fpc <= {redirect_pc[31:2], 2'b00}.
  - From IDLE: go to REQ.
  - From REQ with im_ack=1: the returned data is discarded; go to REQ at the new fpc.
  - From REQ with im_ack=0: go to DROP. The old address stays on im_addr; the new target is latched separately.
  - From DROP: update the latched target and stay in DROP. If im_ack=1 that cycle, go to REQ.
- At most one request is outstanding at any time.
- Full with simultaneous push and pop is legal: count is unchanged and both pointers advance.
- The FIFO never overflows, because a request issues only when a slot is guaranteed free.

## Timing
- Reset values:
  - im_req=0, im_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0.
  - occupancy=0, state=IDLE, fpc=RESET_PC.
- Asserting R mid-request abandons it with no DROP. The memory side must tolerate im_req falling before ack.
- First request: im_req=1 in the first cycle after the first rising edge following reset release.
- Fetch-to-valid latency: ack at edge t gives if_valid=1 after edge t (visible in cycle t+1).
- Redirect in cycle t with no outstanding request:
  - im_req carries the target in cycle t+1.
  - With a same-cycle ack, if_valid=1 in cycle t+2.
- Peak throughput: 1 instruction per cycle with zero-wait memory and id_le=1.

## Configuration
- FETCH_BUF_BYPASS_EN defined:
  - When the FIFO is empty, state==REQ, im_ack=1 and redirect=0, im_data and fpc drive if_instr/if_pc combinationally and if_valid=1 in the same cycle.
  - If id_le=1 that cycle, the word is consumed and not pushed.
  - Fetch-to-valid latency is 0 cycles.
- FETCH_BUF_BYPASS_EN undefined:
  - Outputs come from registered FIFO state only; latency is 1 cycle.

## Test plan
- Reset, zero-wait ack, id_le=1: if_pc sequence 0,4,8,12 with if_instr equal to memory words; occupancy ≤1.
- id_le=0 with DEPTH=4: occupancy saturates at 4 and im_req drops to 0. Raising id_le then pops in order 0,4,8,12 and fetch resumes at 16.
- Redirect to 0x100 while 3 entries are queued and no request is outstanding: occupancy=0 next cycle, im_addr=0x100 next cycle, first if_pc=0x100.
- Memory with 3-cycle ack latency, redirect to 0x200 one cycle after a request to 0x8 issues:
  - im_addr holds 0x8 until ack and that data is discarded.
  - The next im_addr is 0x200 and 0x8 never appears on if_pc.
- redirect_pc=0x303: im_addr=0x300.
- Two back-to-back redirects 0x40 then 0x80 during DROP: only 0x80 is fetched.
- R asserted during an outstanding request: all outputs are at reset values immediately. After release, the first im_addr is RESET_PC.
